fs_serial_sub: RTL and testbench



---
 rtl/fs_pkg.sv | 5 +
 rtl/fs_1bit.sv | 11 +
 rtl/fs_serial_sub.sv | 101 ++++++++++
 tb/tb_fs_serial_sub.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package fs_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fs_state_t;
  localparam int FS_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/fs_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bo = borrow out.
module fs_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/fs_serial_sub.sv
// Bit-serial ripple-borrow subtractor (a - b - bin), one bit per clock, valid/ready on both sides.
// Optional signed-overflow output ovf is built when FS_SUB_OVF_EN is defined.
module fs_serial_sub
  import fs_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef FS_SUB_OVF_EN
  , output logic           ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  fs_state_t        state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sh_reg, diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, bout_reg;
  logic             d, bo;
  logic             last_bit;

  fs_1bit u_cell (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .bin(br_reg),
    .d  (d),
    .bo (bo)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

`ifdef FS_SUB_OVF_EN
  logic ovf_reg;
  // br_reg at the final step is the borrow into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (state_reg == BUSY && last_bit)
      ovf_reg <= br_reg ^ bo;
  end
  assign ovf = ovf_reg;
`endif

  // sh_reg accumulates diff bits while busy; diff_reg only changes on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sh_reg    <= '0;
      diff_reg  <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            br_reg    <= bin;
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          sh_reg  <= {d, sh_reg[WIDTH-1:1]};
          br_reg  <= bo;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_bit) begin
            diff_reg  <= {d, sh_reg[WIDTH-1:1]};
            bout_reg  <= bo;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign bout      = bout_reg;
endmodule

// File: tb/tb_fs_serial_sub.sv
// Randomized/exhaustive bench for fs_serial_sub (WIDTH=4) against an arithmetic reference model.
module tb_fs_serial_sub;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] diff;
`ifdef FS_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fs_serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef FS_SUB_OVF_EN
    , .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_diff(input int x, input int y, input int c);
    return (x - y - c) & ((1 << W) - 1);
  endfunction
  function automatic bit ref_bout(input int x, input int y, input int c);
    return x < (y + c);
  endfunction
  function automatic bit ref_ovf(input int x, input int y, input int c);
    int sx, sy, r;
    sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
    r  = sx - sy - c;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic run_op(input int ta, input int tb, input int tc, input int hold, input bit noise);
    int guard, lat, ed;
    bit eb, eo;
    ed = ref_diff(ta, tb, tc);
    eb = ref_bout(ta, tb, tc);
    eo = ref_ovf(ta, tb, tc);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = W'(ta); b = W'(tb); bin = tc[0]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
`ifdef FS_SUB_OVF_EN
    chk("ovf", ovf, eo);
`endif
    for (int i = 0; i < hold; i++) begin
      if (noise) in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_diff", diff, ed);
      chk("hold_bout", bout, eb);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_rise", in_ready, 1);
    chk("diff_kept", diff, ed);
    chk("bout_kept", bout, eb);
`ifdef FS_SUB_OVF_EN
    chk("ovf_kept", ovf, eo);
`endif
    $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d lat=%0d hold=%0d", ta, tb, tc, diff, bout, lat, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef FS_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(9, 3, 0, 0, 1'b0);
    run_op(3, 5, 0, 1, 1'b0);
    run_op(0, 0, 1, 0, 1'b0);
    run_op(8, 1, 0, 2, 1'b0);
    run_op(12, 4, 0, 5, 1'b1);

    // Abort mid-operation with reset in the second busy cycle.
    a = 4'd5; b = 4'd1; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_diff", diff, 0);
    run_op(7, 2, 0, 0, 1'b0);

    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int c = 0; c < 2; c++)
          run_op(x, y, c, int'($urandom_range(0, 3)), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
